// File: rtl/out_ctrl_pkg.sv
// Shared types and constants for the SAP output-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: out_state_t FSM encoding, reset values, count-width helper.
package out_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } out_state_t;

  // Reset value of the Out display latch.
  localparam int OUT_RST = 0;

  // Gap counter width; covers GAP_CYCLES in 0..255.
  localparam int GAP_W = 8;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous DEPTH x DATA_W queue between the OutLoad capture and the peripheral port.
// Latency: pushed byte visible on o_head one edge later when the queue was empty.
// Backpressure: none internally; caller qualifies i_push with not-full and i_pop with not-empty.
// Ports: clk, rst (async active-low), i_push/i_din write tail, i_pop advances head,
//        o_head = entry at head, o_count = entries held (0..DEPTH).
module out_fifo
  import out_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic [cnt_w(DEPTH)-1:0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/output_port_ctrl.sv
// SAP OUT path: latches bus bytes on OutLoad for display, queues them, and paces them
// to a valid/ready peripheral port with GAP_CYCLES idle cycles between transfers.
// Latency: push at edge N -> PortValid after edge N+1. Backpressure: OutStall while queue full;
// loads while full are dropped and set sticky Overflow.
// Ports: clk, rst (async active-low), BusIn/OutLoad capture, Out display latch,
//        PortData/PortValid/PortReady peripheral handshake, Count occupancy, OutStall, Overflow.
// Option: define OUT_PARITY_EN to add PortParity = ^PortData (even parity).
module output_port_ctrl
  import out_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        BusIn,
  input  logic                     OutLoad,
  output logic                     OutStall,
  output logic [DATA_W-1:0]        Out,
  output logic [DATA_W-1:0]        PortData,
  output logic                     PortValid,
`ifdef OUT_PARITY_EN
  output logic                     PortParity,
`endif
  input  logic                     PortReady,
  output logic [cnt_w(DEPTH)-1:0]  Count,
  output logic                     Overflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  out_state_t        r_state;
  logic [GAP_W-1:0]  r_gap;
  logic              r_port_valid;
  logic [DATA_W-1:0] r_out;
  logic              r_overflow;

  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  // Full is judged on the pre-edge count only: a same-edge pop never frees a slot.
  assign w_full = (w_count == FULL_CNT);
  assign w_push = OutLoad & ~w_full;
  assign w_pop  = r_port_valid & PortReady;

  out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (BusIn),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Display latch and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out      <= DATA_W'(OUT_RST);
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_out <= BusIn;
      end
      if (OutLoad && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Port sequencer. PortValid is registered and only falls on a transfer edge,
  // so the FIFO head it qualifies cannot change underneath the peripheral.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_gap        <= '0;
      r_port_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count != '0) begin
            r_state      <= SEND;
            r_port_valid <= 1'b1;
          end
        end
        SEND: begin
          if (PortReady) begin
            if (GAP_CYCLES == 0) begin
              // Back-to-back: keep valid if anything is left after this pop.
              if ((w_count != ONE_CNT) || w_push) begin
                r_state      <= SEND;
                r_port_valid <= 1'b1;
              end else begin
                r_state      <= IDLE;
                r_port_valid <= 1'b0;
              end
            end else begin
              r_state      <= GAP;
              r_port_valid <= 1'b0;
              r_gap        <= GAP_W'(GAP_CYCLES);
            end
          end
        end
        GAP: begin
          r_gap <= r_gap - 1'b1;
          if (r_gap == GAP_W'(1)) begin
            if (w_count != '0) begin
              r_state      <= SEND;
              r_port_valid <= 1'b1;
            end else begin
              r_state      <= IDLE;
              r_port_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_port_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OutStall  = w_full;
  assign Out       = r_out;
  assign PortData  = w_head;
  assign PortValid = r_port_valid;
  assign Count     = w_count;
  assign Overflow  = r_overflow;

`ifdef OUT_PARITY_EN
  assign PortParity = ^w_head;
`endif

endmodule

// File: tb/tb_output_port_ctrl.sv
// Directed plus randomized bench for output_port_ctrl against a queue-based model.
// Latency: n/a. Backpressure: bench drives PortReady directly.
// Model tracks queued bytes, display latch, overflow, and port pacing from the behavioural rules.
module tb_output_port_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int GAP    = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] BusIn;
  logic              OutLoad;
  logic              OutStall;
  logic [DATA_W-1:0] Out;
  logic [DATA_W-1:0] PortData;
  logic              PortValid;
  logic              PortReady;
  logic [CW-1:0]     Count;
  logic              Overflow;
`ifdef OUT_PARITY_EN
  logic              PortParity;
`endif

  output_port_ctrl #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .BusIn      (BusIn),
    .OutLoad    (OutLoad),
    .OutStall   (OutStall),
    .Out        (Out),
    .PortData   (PortData),
    .PortValid  (PortValid),
`ifdef OUT_PARITY_EN
    .PortParity (PortParity),
`endif
    .PortReady  (PortReady),
    .Count      (Count),
    .Overflow   (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_out;
  bit                m_ovf;
  bit                m_valid;
  int                m_gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out   = '0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_gap   = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".Out"},       32'(Out),       32'(m_out));
    chk({where, ".Count"},     32'(Count),     32'(mq.size()));
    chk({where, ".OutStall"},  32'(OutStall),  32'(mq.size() == DEPTH));
    chk({where, ".PortValid"}, 32'(PortValid), 32'(m_valid));
    chk({where, ".Overflow"},  32'(Overflow),  32'(m_ovf));
    if (m_valid) begin
      chk({where, ".PortData"}, 32'(PortData), 32'(mq[0]));
`ifdef OUT_PARITY_EN
      chk({where, ".PortParity"}, 32'(PortParity), 32'(^mq[0]));
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input bit ld, input logic [DATA_W-1:0] d, input bit rdy, input string where);
    int n;
    bit xfer;
    bit pushed;
    OutLoad   = ld;
    BusIn     = d;
    PortReady = rdy;
    n      = mq.size();
    xfer   = m_valid && rdy;
    pushed = ld && (n < DEPTH);
    if (ld && !pushed) m_ovf = 1'b1;
    if (pushed) m_out = d;
    if (m_valid) begin
      if (xfer) begin
        if (GAP == 0) begin
          m_valid = ((n - 1) > 0) || pushed;
        end else begin
          m_valid = 1'b0;
          m_gap   = GAP;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_valid = (n > 0);
    end else begin
      m_valid = (n > 0);
    end
    if (xfer) void'(mq.pop_front());
    if (pushed) mq.push_back(d);
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset(input string where);
    OutLoad   = 1'b0;
    PortReady = 1'b0;
    BusIn     = '0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(where);
    chk({where, ".PortData0"}, 32'(PortData), 32'h0);
    chk({where, ".PortValid0"}, 32'(PortValid), 32'h0);
    #3;
    rst = 1'b1;
  endtask

  int          xfer_t[$];
  logic [7:0]  xfer_d[$];

  initial begin
    rst       = 1'b0;
    OutLoad   = 1'b0;
    BusIn     = '0;
    PortReady = 1'b0;
    model_reset();
    #12;
    rst = 1'b1;

    // 1: load something, then an async reset pulse must clear everything at once.
    step(1'b1, 8'hA7, 1'b0, "t1_load");
    step(1'b0, 8'h00, 1'b0, "t1_idle");
    do_reset("t1_rst");
    chk("t1_Out0", 32'(Out), 32'h0);
    chk("t1_Count0", 32'(Count), 32'h0);

    // 2: single byte with ready high; 2 idle cycles after the transfer.
    step(1'b1, 8'h5C, 1'b1, "t2_push");
    chk("t2_Out", 32'(Out), 32'h5C);
    chk("t2_valid_lat", 32'(PortValid), 32'h0);
    step(1'b0, 8'h00, 1'b1, "t2_valid");
    chk("t2_valid_up", 32'(PortValid), 32'h1);
    chk("t2_data", 32'(PortData), 32'h5C);
    step(1'b0, 8'h00, 1'b1, "t2_gap1");
    chk("t2_gap1_v", 32'(PortValid), 32'h0);
    step(1'b0, 8'h00, 1'b1, "t2_gap2");
    chk("t2_gap2_v", 32'(PortValid), 32'h0);
    step(1'b0, 8'h00, 1'b1, "t2_idle");

    // 3: five loads with peripheral stalled; fifth dropped.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0, "t3_fill");
    end
    chk("t3_Count", 32'(Count), 32'h4);
    chk("t3_Stall", 32'(OutStall), 32'h1);
    chk("t3_Out", 32'(Out), 32'h04);
    chk("t3_Ovf", 32'(Overflow), 32'h1);
    xfer_t.delete();
    xfer_d.delete();
    for (int c = 0; c < 20; c++) begin
      if (PortValid === 1'b1) begin
        xfer_t.push_back(c);
        xfer_d.push_back(PortData);
      end
      step(1'b0, 8'h00, 1'b1, "t3_drain");
    end
    chk("t3_nxfer", 32'(xfer_d.size()), 32'h4);
    for (int i = 0; i < xfer_d.size(); i++) begin
      chk("t3_order", 32'(xfer_d[i]), 32'(i + 1));
      if (i > 0) chk("t3_spacing", 32'(xfer_t[i] - xfer_t[i-1]), 32'h3);
    end

    // 4: full queue, load coincides with a transfer -> load still rejected.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, "t4_fill");
    end
    chk("t4_full", 32'(Count), 32'h4);
    step(1'b1, 8'hEE, 1'b1, "t4_collide");
    chk("t4_Count", 32'(Count), 32'h3);
    chk("t4_Ovf", 32'(Overflow), 32'h1);
    chk("t4_Out", 32'(Out), 32'h13);

    // Let the gap expire so the next byte is offered.
    step(1'b0, 8'h00, 1'b0, "t4_gap");
    step(1'b0, 8'h00, 1'b0, "t4_resend");

    // 5: hold off the peripheral for 6 cycles in SEND.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b0, "t5_hold");
      chk("t5_valid", 32'(PortValid), 32'h1);
      chk("t5_data", 32'(PortData), 32'h11);
    end

    // 6: reset while in GAP with two bytes queued.
    step(1'b0, 8'h00, 1'b1, "t6_xfer");
    chk("t6_pre_count", 32'(Count), 32'h2);
    do_reset("t6_rst");
    chk("t6_Count", 32'(Count), 32'h0);
    step(1'b1, 8'h3C, 1'b1, "t6_push");
    step(1'b0, 8'h00, 1'b1, "t6_valid");
    chk("t6_data", 32'(PortData), 32'h3C);
`ifdef OUT_PARITY_EN
    chk("t6_parity_3c", 32'(PortParity), 32'h0);
`endif
    step(1'b0, 8'h00, 1'b1, "t6_done");
    chk("t6_after", 32'(PortValid), 32'h0);
    step(1'b0, 8'h00, 1'b1, "t6_gap");
    step(1'b0, 8'h00, 1'b1, "t6_idle");
    step(1'b1, 8'h01, 1'b1, "t6_push01");
    step(1'b0, 8'h00, 1'b0, "t6_valid01");
`ifdef OUT_PARITY_EN
    chk("t6_parity_01", 32'(PortParity), 32'h1);
`endif
    chk("t6_data01", 32'(PortData), 32'h01);

    // Randomized traffic with varying load and ready densities.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(0, 3) < ph + 1) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(0, 3) >= ph) ? 1'b1 : 1'b0,
             "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
